// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
//
// Output-side half of the BIST wrapper. While BIST is high, the CUT primary
// outputs are compacted into a Galois-form multiple-input signature register
// (MISR) for PATTERN_COUNT cycles. The final signature is then compared
// against GOLDEN_SIG and the verdict is held until BIST drops.
//
// Optional feature macro: BIST_SIG_READOUT_EN
//   defined     -> 'signature' output port exists and shows the live MISR.
//   not defined -> port absent; only bist_done / bist_pass are observable.
//   MISR update and pass/fail behaviour are identical in both builds.
//
// Ports
//   clk        in   1      rising-edge clock (same clock as pattern generator)
//   rst_n      in   1      synchronous active-low reset
//   BIST       in   1      test-mode request (also drives the input mux select)
//   cut_out    in   OUT_W  CUT primary outputs, bit 0 = N432
//   bist_busy  out  1      high in RUN and COMPARE
//   bist_done  out  1      high in DONE
//   bist_pass  out  1      verdict, valid while bist_done = 1
//   signature  out  SIG_W  live MISR contents (BIST_SIG_READOUT_EN only)
//
// Timing (edge k samples BIST=1 in IDLE)
//   k                  : RUN entered, MISR <- MISR_SEED, cnt <- 0
//   k+1 .. k+PC        : MISR absorbs cut_out present before each edge
//   k+PC               : COMPARE entered
//   k+PC+1             : DONE entered, bist_pass valid
// -----------------------------------------------------------------------------
module bist_response_analyzer #(
    parameter int                 OUT_W         = 7,
    parameter int                 SIG_W         = 16,
    parameter logic [SIG_W-1:0]   MISR_POLY     = 16'h1021,
    parameter logic [SIG_W-1:0]   MISR_SEED     = 16'h0000,
    parameter int                 PATTERN_COUNT = 1000,
    parameter logic [SIG_W-1:0]   GOLDEN_SIG    = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               BIST,
    input  logic [OUT_W-1:0]   cut_out,
    output logic               bist_busy,
    output logic               bist_done,
`ifdef BIST_SIG_READOUT_EN
    output logic               bist_pass,
    output logic [SIG_W-1:0]   signature
`else
    output logic               bist_pass
`endif
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Counter just wide enough to hold PATTERN_COUNT; it only ever reaches
    // PATTERN_COUNT-1, which marks the last compaction edge.
    localparam int              CNT_W    = $clog2(PATTERN_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_COUNT - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [SIG_W-1:0] misr_q,  misr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pass_q,  pass_d;

    // -------------------------------------------------------------------------
    // MISR next value
    // Galois form: shift left, fold the tap mask in when the MSB falls off,
    // then XOR the zero-extended CUT outputs into the low bits. Built this way
    // rather than with a replication so it stays legal when SIG_W == OUT_W.
    // -------------------------------------------------------------------------
    logic [SIG_W-1:0] cut_ext;
    logic [SIG_W-1:0] misr_fb;
    logic [SIG_W-1:0] misr_step;

    always_comb begin
        cut_ext              = '0;
        cut_ext[OUT_W-1:0]   = cut_out;
    end

    assign misr_fb   = misr_q[SIG_W-1] ? MISR_POLY : '0;
    assign misr_step = {misr_q[SIG_W-2:0], 1'b0} ^ misr_fb ^ cut_ext;

    // -------------------------------------------------------------------------
    // Next-state logic
    // BIST low in any non-IDLE state returns to IDLE. In RUN/COMPARE that is
    // an abort: no DONE, verdict untouched (still 0 from run start), MISR
    // keeps its partial value. Holding BIST high in DONE does nothing; a
    // fresh run needs BIST to go low (back to IDLE) and high again.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (BIST) begin
                    state_d = S_RUN;
                    misr_d  = MISR_SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end

            S_RUN: begin
                if (!BIST) begin
                    state_d = S_IDLE;
                end else begin
                    misr_d = misr_step;
                    // Last pattern: perform the final update but leave cnt
                    // at PATTERN_COUNT-1 so it never exceeds that value.
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_COMPARE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_COMPARE: begin
                if (!BIST) begin
                    state_d = S_IDLE;
                end else begin
                    pass_d  = (misr_q == GOLDEN_SIG);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (!BIST) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers, synchronous active-low reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            misr_q  <= MISR_SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers, so there
    // is no combinational path from BIST or cut_out to any pin.
    // -------------------------------------------------------------------------
    assign bist_busy = (state_q == S_RUN) || (state_q == S_COMPARE);
    assign bist_done = (state_q == S_DONE);
    assign bist_pass = pass_q;

`ifdef BIST_SIG_READOUT_EN
    assign signature = misr_q;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// Bench for bist_response_analyzer.
// Instance A: PATTERN_COUNT=4, seed 0, golden 000F.
// Instance B: PATTERN_COUNT=1, seed 8000, golden 1021 (feedback tap check).
// Expected signatures / verdicts come from a bench-side MISR model and are
// queued when stimulus is driven, then popped when the DUT output is due.
// Signature checks are compiled in only when the readout port exists.
// -----------------------------------------------------------------------------
module tb_bist_response_analyzer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        bist_a, bist_b;
    logic [6:0]  cut_a, cut_b;
    logic        busy_a, done_a, pass_a;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_a, sig_b;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] sig_sb[$];
    bit          pass_sb[$];
    logic [15:0] model;

    bist_response_analyzer #(
        .OUT_W(7), .SIG_W(16), .MISR_POLY(16'h1021), .MISR_SEED(16'h0000),
        .PATTERN_COUNT(4), .GOLDEN_SIG(16'h000F)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .BIST(bist_a), .cut_out(cut_a),
        .bist_busy(busy_a), .bist_done(done_a),
`ifdef BIST_SIG_READOUT_EN
        .bist_pass(pass_a), .signature(sig_a)
`else
        .bist_pass(pass_a)
`endif
    );

    bist_response_analyzer #(
        .OUT_W(7), .SIG_W(16), .MISR_POLY(16'h1021), .MISR_SEED(16'h8000),
        .PATTERN_COUNT(1), .GOLDEN_SIG(16'h1021)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .BIST(bist_b), .cut_out(cut_b),
        .bist_busy(busy_b), .bist_done(done_b),
`ifdef BIST_SIG_READOUT_EN
        .bist_pass(pass_b), .signature(sig_b)
`else
        .bist_pass(pass_b)
`endif
    );

`ifndef BIST_SIG_READOUT_EN
    assign sig_a = 16'h0;
    assign sig_b = 16'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mstep(input logic [15:0] m, input logic [6:0] c);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {9'b0, c};
    endfunction

    // Pop next expected signature; compare only when the port exists.
    task automatic pop_sig(input string tag, input logic [15:0] got);
        logic [15:0] e;
        if (sig_sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sig_sb.pop_front();
`ifdef BIST_SIG_READOUT_EN
            chk(tag, got, e);
`endif
        end
    endtask

    task automatic start_a();
        bist_a = 1'b1;
        step();
        model = 16'h0000;
        sig_sb.push_back(model);
        pop_sig("sig_seed", sig_a);
        chk("busy_start", busy_a, 1);
        chk("done_start", done_a, 0);
        chk("pass_start", pass_a, 0);
    endtask

    task automatic run_cycles(input logic [3:0][6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            cut_a = p[i];
            model = mstep(model, p[i]);
            sig_sb.push_back(model);
            step();
            pop_sig("sig_run", sig_a);
            chk("busy_run", busy_a, 1);
            chk("done_run", done_a, 0);
        end
    endtask

    // Called with A in COMPARE; waits (bounded) for DONE and checks verdict.
    task automatic finish_a();
        int  lat;
        bit  found;
        bit  ep;
        lat   = 4;
        found = 1'b0;
        cut_a = 7'h55;  // must not be absorbed after the last pattern
        pass_sb.push_back(model == 16'h000F);
        for (int w = 0; w < 20 && !found; w++) begin
            step();
            lat++;
            if (done_a) found = 1'b1;
        end
        if (!found) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_lat", lat, 5);
            ep = pass_sb.pop_front();
            chk("pass", pass_a, {31'b0, ep});
            chk("busy_done", busy_a, 0);
            sig_sb.push_back(model);
            pop_sig("sig_done", sig_a);
        end
    endtask

    task automatic end_a();
        bist_a = 1'b0;
        step();
        chk("busy_idle", busy_a, 0);
        chk("done_idle", done_a, 0);
        chk("pass_idle", pass_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] p;
        bit              ep;

        rst_n = 1'b0; bist_a = 1'b0; bist_b = 1'b0; cut_a = '0; cut_b = '0;
        step(); step();
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_pass_a", pass_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_pass_b", pass_b, 0);
`ifdef BIST_SIG_READOUT_EN
        chk("rst_sig_a", sig_a, 16'h0000);
        chk("rst_sig_b", sig_b, 16'h8000);
`endif
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy_a, 0);

        // Pass run, then hold BIST high in DONE for 10 cycles.
        for (int i = 0; i < 4; i++) p[i] = 7'h01;
        start_a();
        run_cycles(p, 4);
        finish_a();
        ep = (model == 16'h000F);
        for (int i = 0; i < 10; i++) begin
            cut_a = 7'($urandom);
            step();
            chk("hold_done", done_a, 1);
            chk("hold_busy", busy_a, 0);
            chk("hold_pass", pass_a, {31'b0, ep});
        end
        end_a();

        // Fail run: third pattern zero.
        p[0] = 7'h01; p[1] = 7'h01; p[2] = 7'h00; p[3] = 7'h01;
        start_a();
        run_cycles(p, 4);
        finish_a();
        end_a();

        // Feedback tap check on instance B.
        bist_b = 1'b1; cut_b = 7'h00;
        step();
        chk("b_busy_run", busy_b, 1);
        pass_sb.push_back(1'b1);
        sig_sb.push_back(mstep(16'h8000, 7'h00));
        step();
        chk("b_busy_cmp", busy_b, 1);
        chk("b_done_cmp", done_b, 0);
        step();
        chk("b_done", done_b, 1);
        ep = pass_sb.pop_front();
        chk("b_pass", pass_b, {31'b0, ep});
        pop_sig("b_sig", sig_b);
        bist_b = 1'b0;
        step();
        chk("b_done_clr", done_b, 0);
        chk("b_pass_clr", pass_b, 0);

        // Abort after 2 RUN cycles, then restart from seed.
        for (int i = 0; i < 4; i++) p[i] = 7'h01;
        start_a();
        run_cycles(p, 2);
        bist_a = 1'b0;
        step();
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_pass", pass_a, 0);
        sig_sb.push_back(model);
        pop_sig("abort_sig", sig_a);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_nodone", done_a, 0);
        end
        start_a();
        run_cycles(p, 4);
        finish_a();
        end_a();

        // Abort in COMPARE on a run that would have passed.
        start_a();
        run_cycles(p, 4);
        bist_a = 1'b0;
        step();
        chk("cabort_busy", busy_a, 0);
        chk("cabort_pass", pass_a, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cabort_nodone", done_a, 0);
        end

        // Reset mid-RUN with BIST still high.
        p[0] = 7'h7F; p[1] = 7'h2A; p[2] = 7'h11; p[3] = 7'h03;
        start_a();
        run_cycles(p, 2);
        rst_n = 1'b0;
        step();
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
        chk("mrst_pass", pass_a, 0);
        sig_sb.push_back(16'h0000);
        pop_sig("mrst_sig", sig_a);
        rst_n = 1'b1; bist_a = 1'b0;
        step();
        chk("mrst_idle", busy_a, 0);

        // Random patterns, full runs.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) p[i] = 7'($urandom);
            start_a();
            run_cycles(p, 4);
            finish_a();
            end_a();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
